// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between the requesters/FIFO and fifo_write_arbiter.
// The master modport is the requester/FIFO side; the slave modport is the arbiter.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int NUM     = 128
);
  localparam int CW = $clog2(NUM + 1);

  logic [NUM_REQ-1:0]       IN_valid;
  logic [NUM_REQ*WIDTH-1:0] IN_data;
  logic [NUM_REQ-1:0]       OUT_ready;
  logic                     OUT_valid;
  logic [WIDTH-1:0]         OUT_data;
  logic                     IN_deq;
  logic                     IN_flush;
  logic [CW-1:0]            OUT_count;
  logic                     OUT_full;
  logic                     OUT_drained;
  logic                     OUT_err;

  modport master (
    output IN_valid, IN_data, IN_deq, IN_flush,
    input  OUT_ready, OUT_valid, OUT_data, OUT_count, OUT_full, OUT_drained, OUT_err
  );

  modport slave (
    input  IN_valid, IN_data, IN_deq, IN_flush,
    output OUT_ready, OUT_valid, OUT_data, OUT_count, OUT_full, OUT_drained, OUT_err
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// with credit-based occupancy tracking and a flush/drain handshake.
module fifo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int NUM     = 128
) (
  input logic               clk,
  input logic               rst,
  fifo_write_arbiter_if.slave bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW   = $clog2(NUM + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(NUM);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_REQ - 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE, IDLE} state_t;

  state_t            state, stateNext;
  logic [IDXW-1:0]   last, grantIdx;
  logic [NUM_REQ-1:0] grant;
  logic              found;
  logic [WIDTH-1:0]  dataSel;
  logic [CW-1:0]     count;
  logic              outValid;
  logic [WIDTH-1:0]  outData;
  logic              err;
  logic              drained;
  logic              full;
  int unsigned       idx;

  assign full = (count == CNT_MAX);

  // Search starts one past the last winner and wraps, giving round-robin order.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = 0;
    if (state == RUN && !full) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = 32'(last) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && bus.IN_valid[IDXW'(idx)]) begin
          found                 = 1'b1;
          grant[IDXW'(idx)]     = 1'b1;
          grantIdx              = IDXW'(idx);
        end
      end
    end
  end

  always_comb begin
    dataSel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) dataSel = dataSel | bus.IN_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    stateNext = state;
    drained   = 1'b0;
    case (state)
      RUN:   if (bus.IN_flush) stateNext = DRAIN;
      DRAIN: if (count == '0 && !outValid) stateNext = DONE;
      DONE: begin
        drained   = 1'b1;
        stateNext = bus.IN_flush ? IDLE : RUN;
      end
      IDLE:  if (!bus.IN_flush) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      last     <= LAST_RST;
      count    <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= stateNext;
      outValid <= found;
      if (found) begin
        outData <= dataSel;
        last    <= grantIdx;
      end
      // A transfer and a pop in the same cycle cancel out.
      if (found && !bus.IN_deq) begin
        count <= count + 1'b1;
      end else if (!found && bus.IN_deq) begin
        if (count == '0) err   <= 1'b1;
        else             count <= count - 1'b1;
      end
    end
  end

  assign bus.OUT_ready   = grant;
  assign bus.OUT_valid   = outValid;
  assign bus.OUT_data    = outData;
  assign bus.OUT_count   = count;
  assign bus.OUT_full    = full;
  assign bus.OUT_drained = drained;
  assign bus.OUT_err     = err;
endmodule
